// File: rtl/troco_dispenser_if.sv
// Handshake bundle between the vending core / coin ejector and the change-return engine.
// The master side drives the payout request and the ejector acknowledge.
interface troco_dispenser_if;
    logic       start;
    logic [7:0] amount;
    logic       coin_ack;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       busy;
    logic       done;
    logic [7:0] residual;
    logic       fault;

    modport master (
        output start, amount, coin_ack,
        input  coin_req, coin_sel, busy, done, residual, fault
    );

    modport slave (
        input  start, amount, coin_ack,
        output coin_req, coin_sel, busy, done, residual, fault
    );
endinterface

// File: rtl/troco_dispenser.sv
// Change-return engine: pays an amount back through the coin ejector, one coin per
// req/ack handshake, greedy largest-denomination first; reports residual and timeouts.
module troco_dispenser #(
    parameter int unsigned D0          = 50,
    parameter int unsigned D1          = 25,
    parameter int unsigned D2          = 10,
    parameter int unsigned D3          = 5,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned ACK_TIMEOUT = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    troco_dispenser_if.slave   bus
);

    localparam int unsigned TW       = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam int unsigned GW       = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam int unsigned TMR_LAST = ACK_TIMEOUT - 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        REQ,
        GAP,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      remaining_q, remaining_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [1:0]      sel_q, sel_d;
    logic [7:0]      residual_q, residual_d;
    logic            fault_q, fault_d;

    function automatic logic [7:0] denom(input logic [1:0] slot);
        case (slot)
            2'd0:    denom = 8'(D0);
            2'd1:    denom = 8'(D1);
            2'd2:    denom = 8'(D2);
            default: denom = 8'(D3);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            timer_q     <= '0;
            gap_q       <= '0;
            sel_q       <= '0;
            residual_q  <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            gap_q       <= gap_d;
            sel_q       <= sel_d;
            residual_q  <= residual_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        sel_d       = sel_q;
        residual_d  = residual_q;
        fault_d     = fault_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.amount;
                    fault_d     = 1'b0;
                    residual_d  = '0;
                    state_d     = SELECT;
                end
            end
            SELECT: begin
                timer_d = '0;
                state_d = REQ;
                if (remaining_q >= 8'(D0))      sel_d = 2'd0;
                else if (remaining_q >= 8'(D1)) sel_d = 2'd1;
                else if (remaining_q >= 8'(D2)) sel_d = 2'd2;
                else if (remaining_q >= 8'(D3)) sel_d = 2'd3;
                else begin
                    residual_d = remaining_q;
                    state_d    = DONE;
                end
            end
            REQ: begin
                // An ack arriving on the final timeout cycle still counts as a paid coin.
                if (bus.coin_ack) begin
                    remaining_d = remaining_q - denom(sel_q);
                    gap_d       = '0;
                    state_d     = (GAP_CYCLES == 0) ? SELECT : GAP;
                end else if (timer_q == TW'(TMR_LAST)) begin
                    remaining_d = '0;
                    fault_d     = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_LAST)) state_d = SELECT;
                else                        gap_d   = gap_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.coin_req = (state_q == REQ);
        bus.coin_sel = sel_q;
        bus.busy     = (state_q != IDLE);
        bus.done     = (state_q == DONE);
        bus.residual = residual_q;
        bus.fault    = fault_q;
    end

endmodule

// File: tb/tb_troco_dispenser.sv
// Directed bench for troco_dispenser: table of payouts plus timeout, noise and
// mid-payout reset sequences.
module tb_troco_dispenser;

    localparam int unsigned GAP   = 2;
    localparam int unsigned ACKTO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    troco_dispenser_if bus ();

    troco_dispenser #(
        .D0(50), .D1(25), .D2(10), .D3(5),
        .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACKTO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  amount;
        int          delay;
        int          n;
        logic [15:0] sels;
        logic [7:0]  res;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_payout(input string tag, input logic [7:0] amt, input int delay,
                              input int exp_n, input logic [15:0] exp_sels,
                              input logic [7:0] exp_res, input bit noise);
        int          cyc;
        int          ncoin;
        int          done_cyc;
        int          busy_drop;
        int          unstable;
        int          waitc;
        bit          prev_req;
        bit          finished;
        logic [1:0]  cur_sel;
        logic [7:0]  got_res;
        logic [15:0] got_sels;
        cyc = 0; ncoin = 0; done_cyc = -1; busy_drop = 0; unstable = 0; waitc = 0;
        prev_req = 1'b0; finished = 1'b0; cur_sel = '0; got_res = '0; got_sels = '0;

        bus.amount = amt;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        check($sformatf("%s_busy_after_start", tag), 32'(bus.busy), 32'd1);
        check($sformatf("%s_fault_cleared", tag), 32'(bus.fault), 32'd0);

        while (!finished && cyc < 2000) begin
            tick();
            cyc++;
            bus.coin_ack = 1'b0;
            bus.start    = 1'b0;
            if (bus.done) begin
                done_cyc = cyc;
                got_res  = bus.residual;
                finished = 1'b1;
            end else if (!bus.busy) begin
                busy_drop++;
            end
            if (bus.coin_req) begin
                if (!prev_req) begin
                    if (ncoin < 8) got_sels[2*ncoin +: 2] = bus.coin_sel;
                    ncoin++;
                    cur_sel = bus.coin_sel;
                    waitc   = 0;
                end else if (bus.coin_sel !== cur_sel) begin
                    unstable++;
                end
                waitc++;
                if (waitc == delay) bus.coin_ack = 1'b1;
            end else if (noise && prev_req) begin
                bus.coin_ack = 1'b1;
                bus.start    = 1'b1;
                bus.amount   = 8'd255;
            end
            prev_req = bus.coin_req;
        end

        check($sformatf("%s_done_seen", tag), 32'(finished), 32'd1);
        check($sformatf("%s_coins", tag), 32'(ncoin), 32'(exp_n));
        check($sformatf("%s_sels", tag), 32'(got_sels), 32'(exp_sels));
        check($sformatf("%s_sel_stable", tag), 32'(unstable), 32'd0);
        check($sformatf("%s_busy_held", tag), 32'(busy_drop), 32'd0);
        check($sformatf("%s_residual", tag), 32'(got_res), 32'(exp_res));
        check($sformatf("%s_done_cycle", tag), 32'(done_cyc), 32'(1 + exp_n * (delay + int'(GAP) + 1)));
        tick();
        check($sformatf("%s_done_single", tag), 32'(bus.done), 32'd0);
        check($sformatf("%s_busy_end", tag), 32'(bus.busy), 32'd0);
        check($sformatf("%s_residual_held", tag), 32'(bus.residual), 32'(exp_res));
    endtask

    initial begin
        int req_cnt;
        int done_cnt;
        int stray;
        bit found;

        bus.start    = 1'b0;
        bus.amount   = '0;
        bus.coin_ack = 1'b0;
        rst_n        = 1'b0;

        vecs[0] = '{8'd85,  3, 3, 16'h0024, 8'd0};
        vecs[1] = '{8'd7,   2, 1, 16'h0003, 8'd2};
        vecs[2] = '{8'd0,   1, 0, 16'h0000, 8'd0};
        vecs[3] = '{8'd255, 1, 6, 16'h0C00, 8'd0};
        vecs[4] = '{8'd40,  2, 3, 16'h0039, 8'd0};
        vecs[5] = '{8'd99,  1, 4, 16'h00A4, 8'd4};
        vecs[6] = '{8'd4,   1, 0, 16'h0000, 8'd4};

        repeat (3) tick();
        check("rst_coin_req", 32'(bus.coin_req), 32'd0);
        check("rst_coin_sel", 32'(bus.coin_sel), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_residual", 32'(bus.residual), 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_payout($sformatf("vec%0d", i), vecs[i].amount, vecs[i].delay,
                       vecs[i].n, vecs[i].sels, vecs[i].res, 1'b0);
        end

        // Stray start and ack during the gap must not alter the payout.
        run_payout("noise", 8'd85, 3, 3, 16'h0024, 8'd0, 1'b1);

        // Ejector never acknowledges.
        req_cnt = 0; done_cnt = 0;
        bus.amount = 8'd10;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.coin_req) req_cnt++;
            if (bus.done) done_cnt++;
        end
        check("to_req_cycles", 32'(req_cnt), 32'(ACKTO));
        check("to_no_done", 32'(done_cnt), 32'd0);
        check("to_fault", 32'(bus.fault), 32'd1);
        check("to_busy", 32'(bus.busy), 32'd0);
        run_payout("after_fault", 8'd10, 2, 1, 16'h0002, 8'd0, 1'b0);

        // Reset while a coin request is outstanding.
        found = 1'b0;
        bus.amount = 8'd10;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (bus.coin_req) found = 1'b1;
        end
        check("mr_req_seen", 32'(found), 32'd1);
        check("mr_sel_before", 32'(bus.coin_sel), 32'd2);
        rst_n = 1'b0;
        tick();
        check("mr_coin_req", 32'(bus.coin_req), 32'd0);
        check("mr_coin_sel", 32'(bus.coin_sel), 32'd0);
        check("mr_busy", 32'(bus.busy), 32'd0);
        check("mr_done", 32'(bus.done), 32'd0);
        check("mr_residual", 32'(bus.residual), 32'd0);
        check("mr_fault", 32'(bus.fault), 32'd0);
        rst_n = 1'b1;
        bus.coin_ack = 1'b1;
        tick();
        bus.coin_ack = 1'b0;
        stray = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.coin_req || bus.busy || bus.done) stray++;
        end
        check("mr_stray_ack", 32'(stray), 32'd0);
        run_payout("after_reset", 8'd7, 1, 1, 16'h0003, 8'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
